tala_sequencer: RTL and testbench
=================================

TALA_SEQUENCER -- requirements
Module: tala_sequencer

Interface
REQ-001 Parameter BEAT_CYCLES, default 16, clk cycles per beat at speed_sel=0; SHALL be a multiple of 16 and at least 16.
REQ-002 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset; synchronous and active-high.
REQ-004 Port en  input  1  run enable; low freezes all state.
REQ-005 Port speed_sel  input  2  tempo select; beat period P = BEAT_CYCLES >> speed_sel.
REQ-006 Port tala_sel  input  2  tala select: 0 Adi (8 beats), 1 Rupaka (6), 2 Eka (4), 3 Tisra Triputa (7).
REQ-007 Port led  output  2  beat action: 01 clap, 10 wave, 11 finger count, 00 dark.
REQ-008 Port beat_idx  output  4  current beat within the avartana, 0-based.
REQ-009 Port beat_tick  output  1  high during the first cycle of every beat.
REQ-010 Port sam  output  1  high during the first cycle of beat 0.

Function
REQ-011 Internal state SHALL be: phase counter ph (0..P-1), beat counter, latched speed, latched tala, and the TALA_CYCLE_CNT_EN counter when that feature is compiled in.
REQ-012 With en=1, ph SHALL increment each cycle; at ph=P-1 it SHALL wrap to 0 and the beat counter SHALL advance.
REQ-013 The beat counter SHALL wrap from the last beat of the latched tala (7, 5, 3 or 6) to 0.
REQ-014 speed_sel and tala_sel SHALL be latched only on the cycle the beat counter wraps to 0, and during reset; changes mid-avartana SHALL take effect at the next sam.
REQ-015 Action tables: Adi = 01,11,11,11,01,10,01,10; Rupaka = 01,10,01,11,11,11; Eka = 01,11,11,11; Tisra Triputa = 01,11,11,01,10,01,10.
REQ-016 led SHALL equal the table entry for (latched tala, beat) while en=1 and ph < P/2, and SHALL be 00 otherwise.
REQ-017 beat_tick SHALL equal en AND (ph==0).
REQ-018 sam SHALL equal beat_tick AND (beat==0).
REQ-019 beat_idx SHALL show the beat counter regardless of en.
REQ-020 With en=0: ph, the beat counter and the latches SHALL hold; led=00; beat_tick=0; sam=0.
REQ-021 When en rises again, the sequence SHALL resume from the held ph and beat; no tick is re-issued unless ph==0.
REQ-022 At speed_sel=3 with BEAT_CYCLES=16, P=2: led SHALL be lit for exactly 1 cycle per beat.

Reset
REQ-023 While rst=1: ph=0, beat=0, led=00, beat_tick=0, sam=0, and the cycle counter = 0.
REQ-024 While rst=1, speed_sel and tala_sel SHALL be latched.
REQ-025 rst SHALL take priority over en.
REQ-026 In the first cycle after rst falls, with en=1: sam=1, beat_tick=1, led=01, beat_idx=0.
REQ-027 Asserting rst mid-beat SHALL abandon the current avartana with no partial pulses.

Configuration
REQ-028 Macro TALA_CYCLE_CNT_EN SHALL control one feature: the avartana counter.
REQ-029 When TALA_CYCLE_CNT_EN is defined: an output port cycle_cnt (8 bits) SHALL exist.
REQ-030 cycle_cnt SHALL increment on each beat-counter wrap to 0, wrap from 255 to 0, and hold while en=0.
REQ-031 When TALA_CYCLE_CNT_EN is undefined: the cycle_cnt port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 BEAT_CYCLES=16, tala 0, speed 0, en=1 after rst:
- sam at cycles 0, 128, 256;
- led per beat = 01,11,11,11,01,10,01,10, each lit 8 cycles then 00 for 8.
REQ-033 Tala 1, speed 3:
- sam every 12 cycles;
- led sequence 01,00,10,00,01,00,11,00,11,00,11,00.
REQ-034 Tala 0 running; switch to tala 2 and speed 1 at beat 3:
- Adi continues unchanged to beat 7;
- from the next sam: 4-beat cycle, P=8, sam every 32 cycles.
REQ-035 en=0 for 20 cycles at ph=5 of beat 2:
- led=00, beat_tick=0, beat_idx=2 throughout;
- after re-enable, the next beat_tick occurs 11 cycles later (ph 5->15 then 0).
REQ-036 rst pulsed at beat 5, ph 3 of tala 3:
- next cycle: sam=1, led=01, beat_idx=0.
REQ-037 With TALA_CYCLE_CNT_EN defined, tala 2, speed 3:
- after 256 avartanas, cycle_cnt returns to 0;
- cycle_cnt holds across en=0.

Source files
------------

// File: rtl/tala_sequencer.sv
// Carnatic tala beat sequencer: beat phase/beat counters, with LED actions taken from per-tala tables.
// Outputs are combinational from state. The optional avartana counter is controlled by the TALA_CYCLE_CNT_EN macro.
module tala_sequencer #(
  parameter int BEAT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] speed_sel,
  input  logic [1:0] tala_sel,
  output logic [1:0] led,
  output logic [3:0] beat_idx,
  output logic       beat_tick,
  output logic       sam
`ifdef TALA_CYCLE_CNT_EN
  ,
  output logic [7:0] cycle_cnt
`endif
);

  localparam int PW = $clog2(BEAT_CYCLES);
  localparam logic [PW:0] BC  = (PW+1)'(BEAT_CYCLES);
  localparam logic [PW:0] ONE = (PW+1)'(1);

  // Action tables, beat 0 in the low bits: 01 clap, 10 wave, 11 finger count.
  localparam logic [15:0] ADI    = {2'b10, 2'b01, 2'b10, 2'b01, 2'b11, 2'b11, 2'b11, 2'b01};
  localparam logic [15:0] RUPAKA = {2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b01, 2'b10, 2'b01};
  localparam logic [15:0] EKA    = {2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b01};
  localparam logic [15:0] TISRA  = {2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b11, 2'b11, 2'b01};

  logic [PW-1:0] ph;
  logic [3:0]    beat;
  logic [1:0]    spd;
  logic [1:0]    tala;
`ifdef TALA_CYCLE_CNT_EN
  logic [7:0]    cnt;
`endif

  logic [PW:0]   period;
  logic [PW:0]   ph_ext;
  logic          ph_wrap;
  logic          beat_wrap;
  logic          lit;
  logic [3:0]    last_beat;
  logic [15:0]   row;
  logic [1:0]    act;

  always_comb begin
    period    = BC >> spd;
    ph_ext    = {1'b0, ph};
    ph_wrap   = (ph_ext == period - ONE);
    lit       = (ph_ext < (period >> 1));
    last_beat = 4'd7;
    row       = ADI;
    case (tala)
      2'd0: begin last_beat = 4'd7; row = ADI;    end
      2'd1: begin last_beat = 4'd5; row = RUPAKA; end
      2'd2: begin last_beat = 4'd3; row = EKA;    end
      default: begin last_beat = 4'd6; row = TISRA; end
    endcase
    beat_wrap = ph_wrap && (beat == last_beat);
    act       = row[{beat[2:0], 1'b0} +: 2];
  end

  // Speed and tala are only re-latched at the avartana boundary so a cycle never changes shape mid-way.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph   <= '0;
      beat <= 4'd0;
      spd  <= speed_sel;
      tala <= tala_sel;
`ifdef TALA_CYCLE_CNT_EN
      cnt  <= 8'd0;
`endif
    end else if (en) begin
      if (ph_wrap) begin
        ph <= '0;
        if (beat_wrap) begin
          beat <= 4'd0;
          spd  <= speed_sel;
          tala <= tala_sel;
`ifdef TALA_CYCLE_CNT_EN
          cnt  <= cnt + 8'd1;
`endif
        end else begin
          beat <= beat + 4'd1;
        end
      end else begin
        ph <= ph + PW'(1);
      end
    end
  end

  // Outputs are masked by rst so nothing leaks while the registers are being cleared.
  always_comb begin
    led       = (!rst && en && lit) ? act : 2'b00;
    beat_tick = !rst && en && (ph == '0);
    sam       = beat_tick && (beat == 4'd0);
    beat_idx  = rst ? 4'd0 : beat;
  end

`ifdef TALA_CYCLE_CNT_EN
  assign cycle_cnt = rst ? 8'd0 : cnt;
`endif

endmodule

// File: tb/tb_tala_sequencer.sv
// Bench for tala_sequencer: vector table, directed multi-cycle sequences, and randomized run against a pattern model.
module tb_tala_sequencer;

  localparam int BC = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] speed_sel;
  logic [1:0] tala_sel;
  logic [1:0] led;
  logic [3:0] beat_idx;
  logic       beat_tick;
  logic       sam;
`ifdef TALA_CYCLE_CNT_EN
  logic [7:0] cycle_cnt;
`endif

  always #5 clk = ~clk;

  tala_sequencer #(.BEAT_CYCLES(BC)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .speed_sel (speed_sel),
    .tala_sel  (tala_sel),
    .led       (led),
    .beat_idx  (beat_idx),
    .beat_tick (beat_tick),
    .sam       (sam)
`ifdef TALA_CYCLE_CNT_EN
    ,
    .cycle_cnt (cycle_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  int act_tbl [4][8] = '{'{1, 3, 3, 3, 1, 2, 1, 2},
                         '{1, 2, 1, 3, 3, 3, 0, 0},
                         '{1, 3, 3, 3, 0, 0, 0, 0},
                         '{1, 3, 3, 1, 2, 1, 2, 0}};

  // Model state: position within the current avartana in enabled cycles.
  int m_pos = 0, m_tala = 0, m_spd = 0, m_cnt = 0;
  bit last_sam, last_tick;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int nbeats(input int t);
    case (t)
      0: return 8;
      1: return 6;
      2: return 4;
      default: return 7;
    endcase
  endfunction

  task automatic check_model();
    int p, b, w, el, et, es, ei;
    p  = BC >> m_spd;
    b  = m_pos / p;
    w  = m_pos % p;
    el = (!rst && en && w < p / 2) ? act_tbl[m_tala][b] : 0;
    et = (!rst && en && w == 0) ? 1 : 0;
    es = (et == 1 && b == 0) ? 1 : 0;
    ei = rst ? 0 : b;
    chk("led", int'(led), el);
    chk("beat_tick", int'(beat_tick), et);
    chk("sam", int'(sam), es);
    chk("beat_idx", int'(beat_idx), ei);
`ifdef TALA_CYCLE_CNT_EN
    chk("cycle_cnt", int'(cycle_cnt), rst ? 0 : m_cnt);
`endif
  endtask

  task automatic clock_model();
    if (rst) begin
      m_pos = 0; m_tala = int'(tala_sel); m_spd = int'(speed_sel); m_cnt = 0;
    end else if (en) begin
      m_pos++;
      if (m_pos == nbeats(m_tala) * (BC >> m_spd)) begin
        m_pos  = 0;
        m_tala = int'(tala_sel);
        m_spd  = int'(speed_sel);
        m_cnt  = (m_cnt + 1) % 256;
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    clock_model();
    @(negedge clk);
  endtask

  task automatic tick();
    #1;
    check_model();
    last_sam  = sam;
    last_tick = beat_tick;
    adv();
  endtask

  task automatic reset_run(input int t, input int s);
    rst = 1'b1; en = 1'b1; tala_sel = 2'(t); speed_sel = 2'(s);
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    bit r; bit e; int t; int s;
    int led; int tick; int sam; int idx;
  } vec_t;
  vec_t vecs[19];

  int sams[$];
  int exp_a[3] = '{0, 128, 256};
  int exp_b[4] = '{0, 128, 160, 192};
  int found;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Rupaka at speed 3: P=2, 12-cycle avartana; then reset into Eka.
    vecs[0]  = '{1, 1, 1, 3, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 1, 3, 1, 1, 1, 0};
    vecs[2]  = '{0, 1, 1, 3, 0, 0, 0, 0};
    vecs[3]  = '{0, 1, 1, 3, 2, 1, 0, 1};
    vecs[4]  = '{0, 1, 1, 3, 0, 0, 0, 1};
    vecs[5]  = '{0, 1, 1, 3, 1, 1, 0, 2};
    vecs[6]  = '{0, 1, 1, 3, 0, 0, 0, 2};
    vecs[7]  = '{0, 1, 1, 3, 3, 1, 0, 3};
    vecs[8]  = '{0, 1, 1, 3, 0, 0, 0, 3};
    vecs[9]  = '{0, 0, 1, 3, 0, 0, 0, 4};
    vecs[10] = '{0, 1, 1, 3, 3, 1, 0, 4};
    vecs[11] = '{0, 1, 1, 3, 0, 0, 0, 4};
    vecs[12] = '{0, 1, 1, 3, 3, 1, 0, 5};
    vecs[13] = '{0, 1, 1, 3, 0, 0, 0, 5};
    vecs[14] = '{0, 1, 1, 3, 1, 1, 1, 0};
    vecs[15] = '{1, 1, 2, 3, 0, 0, 0, 0};
    vecs[16] = '{0, 1, 2, 3, 1, 1, 1, 0};
    vecs[17] = '{0, 1, 2, 3, 0, 0, 0, 0};
    vecs[18] = '{0, 1, 2, 3, 3, 1, 0, 1};

    rst = 1'b1; en = 1'b0; tala_sel = 2'd0; speed_sel = 2'd0;
    @(negedge clk);

    foreach (vecs[i]) begin
      rst = vecs[i].r; en = vecs[i].e;
      tala_sel = 2'(vecs[i].t); speed_sel = 2'(vecs[i].s);
      #1;
      chk($sformatf("vec%0d_led", i), int'(led), vecs[i].led);
      chk($sformatf("vec%0d_tick", i), int'(beat_tick), vecs[i].tick);
      chk($sformatf("vec%0d_sam", i), int'(sam), vecs[i].sam);
      chk($sformatf("vec%0d_idx", i), int'(beat_idx), vecs[i].idx);
      adv();
    end

    // Adi at speed 0: sam every 128 cycles.
    reset_run(0, 0);
    sams.delete();
    for (int i = 0; i < 260; i++) begin
      tick();
      if (last_sam) sams.push_back(i);
    end
    chk("adi_sam_count", sams.size(), 3);
    for (int k = 0; k < 3 && k < sams.size(); k++) chk("adi_sam_pos", sams[k], exp_a[k]);

    // Switch to Eka/speed 1 at beat 3; takes effect at the next sam.
    reset_run(0, 0);
    sams.delete();
    for (int i = 0; i < 200; i++) begin
      if (i == 48) begin
        chk("switch_at_beat3", int'(beat_idx), 3);
        tala_sel = 2'd2; speed_sel = 2'd1;
      end
      tick();
      if (last_sam) sams.push_back(i);
    end
    chk("switch_sam_count", sams.size(), 4);
    for (int k = 0; k < 4 && k < sams.size(); k++) chk("switch_sam_pos", sams[k], exp_b[k]);

    // Pause at beat 2, ph 5 for 20 cycles.
    reset_run(0, 0);
    for (int i = 0; i < 37; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("pause_idx", int'(beat_idx), 2);
    end
    en = 1'b1;
    found = -1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (last_tick && found < 0) found = k;
    end
    chk("resume_gap", found, 11);

    // Reset mid-beat in Tisra Triputa (beat 5, ph 3).
    reset_run(3, 0);
    for (int i = 0; i < 83; i++) tick();
    chk("pre_rst_idx", int'(beat_idx), 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_sam", int'(sam), 1);
    chk("post_rst_led", int'(led), 1);
    chk("post_rst_idx", int'(beat_idx), 0);
    tick();

`ifdef TALA_CYCLE_CNT_EN
    // Eka at speed 3: 8-cycle avartana, 256 of them wrap the counter.
    reset_run(2, 3);
    for (int i = 0; i < 1000; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("cnt_hold", int'(cycle_cnt), 125);
    end
    en = 1'b1;
    for (int i = 0; i < 1048; i++) tick();
    #1;
    chk("cnt_wrap", int'(cycle_cnt), 0);
    adv();
`endif

    // Randomized run against the model.
    reset_run(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      en  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) begin
        tala_sel  = 2'($urandom_range(0, 3));
        speed_sel = 2'($urandom_range(0, 3));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
